aib_axi_credit_arb: RTL and testbench

AIB_AXI_CREDIT_ARB -- requirements
Module: aib_axi_credit_arb

---
 rtl/aib_axi_credit_arb_pkg.sv | 26 ++
 rtl/aib_axi_credit_arb_if.sv | 33 +++
 rtl/aib_axi_rr_arb.sv | 40 ++++
 rtl/aib_axi_credit_arb.sv | 201 ++++++++++++++++++++
 tb/tb_aib_axi_credit_arb.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aib_axi_credit_arb_pkg.sv
// Shared encodings for the AIB AXI credit arbiter: request types, FSM states,
// credit-return bit positions and the port-index width helper.
package aib_axi_credit_arb_pkg;

  typedef enum logic [1:0] {
    TYPE_AW  = 2'b00,
    TYPE_W   = 2'b01,
    TYPE_AR  = 2'b10,
    TYPE_ILL = 2'b11
  } req_type_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int CR_AW  = 0;
  localparam int CR_W   = 1;
  localparam int CR_AR  = 2;
  localparam int NUM_CR = 3;

  function automatic int port_w(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aib_axi_credit_arb_if.sv
// Request and AIB transmit handshake bundle for aib_axi_credit_arb.
// The arbiter uses the slave modport; the request/transmit agent uses master.
interface aib_axi_credit_arb_if
  import aib_axi_credit_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DWIDTH    = 160
);

  localparam int PORT_W = port_w(NUM_PORTS);

  logic [NUM_PORTS-1:0]        req_valid;
  logic [2*NUM_PORTS-1:0]      req_type;
  logic [DWIDTH*NUM_PORTS-1:0] req_data;
  logic [NUM_PORTS-1:0]        req_ready;

  logic                        tx_valid;
  logic                        tx_ready;
  logic [DWIDTH-1:0]           tx_data;
  logic [1:0]                  tx_type;
  logic [PORT_W-1:0]           tx_port;

  modport master (
    output req_valid, req_type, req_data, tx_ready,
    input  req_ready, tx_valid, tx_data, tx_type, tx_port
  );

  modport slave (
    input  req_valid, req_type, req_data, tx_ready,
    output req_ready, tx_valid, tx_data, tx_type, tx_port
  );

endinterface

// File: rtl/aib_axi_rr_arb.sv
// Round-robin picker: first eligible port at or after rr_ptr_i, wrapping
// modulo NUM_PORTS. Purely combinational.
module aib_axi_rr_arb
  import aib_axi_credit_arb_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  localparam int PORT_W    = port_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] eligible_i,
  input  logic [PORT_W-1:0]    rr_ptr_i,
  output logic                 grant_vld_o,
  output logic [PORT_W-1:0]    grant_idx_o,
  output logic [NUM_PORTS-1:0] grant_oh_o
);

  logic found;

  // First pass covers ports from the pointer upward, second pass the wrap.
  always_comb begin
    found       = 1'b0;
    grant_idx_o = '0;
    grant_oh_o  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && eligible_i[i] && (PORT_W'(i) >= rr_ptr_i)) begin
        found         = 1'b1;
        grant_idx_o   = PORT_W'(i);
        grant_oh_o[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && eligible_i[i]) begin
        found         = 1'b1;
        grant_idx_o   = PORT_W'(i);
        grant_oh_o[i] = 1'b1;
      end
    end
    grant_vld_o = found;
  end

endmodule

// File: rtl/aib_axi_credit_arb.sv
// Credit-gated round-robin arbiter of NUM_PORTS AXI request ports onto one
// registered AIB transmit stream. Define AIB_AXI_ARB_STALL_CNT_EN to add stall_cnt.
module aib_axi_credit_arb
  import aib_axi_credit_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DWIDTH    = 160,
  parameter int CREDIT_W  = 8
) (
  input  logic                clk_wr,
  input  logic                rst_wr,
  input  logic                init_load,
  input  logic [CREDIT_W-1:0] init_aw_credit,
  input  logic [CREDIT_W-1:0] init_w_credit,
  input  logic [CREDIT_W-1:0] init_ar_credit,
  input  logic [2:0]          cr_ret,
  output logic [CREDIT_W-1:0] credit_aw,
  output logic [CREDIT_W-1:0] credit_w,
  output logic [CREDIT_W-1:0] credit_ar,
  output logic                run,
  output logic                err,
`ifdef AIB_AXI_ARB_STALL_CNT_EN
  output logic [15:0]         stall_cnt,
`endif
  aib_axi_credit_arb_if.slave bus
);

  localparam int                 PORT_W = port_w(NUM_PORTS);
  localparam logic [CREDIT_W-1:0] CR_MAX = '1;
  localparam logic [CREDIT_W-1:0] CR_ONE = {{(CREDIT_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q [NUM_CR];
  logic [CREDIT_W-1:0] credit_d [NUM_CR];
  logic [PORT_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic                err_q, err_d;
  logic                tx_valid_q, tx_valid_d;
  logic [DWIDTH-1:0]   tx_data_q, tx_data_d;
  logic [1:0]          tx_type_q, tx_type_d;
  logic [PORT_W-1:0]   tx_port_q, tx_port_d;

  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] illegal_req;
  logic [3:0]           cr_avail;
  logic                 can_load;
  logic                 grant_vld;
  logic [PORT_W-1:0]    grant_idx;
  logic [NUM_PORTS-1:0] grant_oh;
  logic [1:0]           gnt_type;
  logic [DWIDTH-1:0]    gnt_data;
  logic [2:0]           dec;

  assign can_load = !tx_valid_q || bus.tx_ready;
  // Index 3 (illegal type) never has credit.
  assign cr_avail = {1'b0, credit_q[CR_AR] != '0, credit_q[CR_W] != '0,
                     credit_q[CR_AW] != '0};

  always_comb begin
    logic [1:0] typ;
    eligible    = '0;
    illegal_req = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      typ            = bus.req_type[2*p +: 2];
      illegal_req[p] = bus.req_valid[p] && (typ == TYPE_ILL);
      eligible[p]    = (state_q == ST_RUN) && bus.req_valid[p] &&
                       (typ != TYPE_ILL) && cr_avail[typ] && can_load;
    end
  end

  aib_axi_rr_arb #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_arb (
    .eligible_i  (eligible),
    .rr_ptr_i    (rr_ptr_q),
    .grant_vld_o (grant_vld),
    .grant_idx_o (grant_idx),
    .grant_oh_o  (grant_oh)
  );

  assign bus.req_ready = grant_oh;

  always_comb begin
    gnt_type = '0;
    gnt_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_oh[p]) begin
        gnt_type = bus.req_type[2*p +: 2];
        gnt_data = bus.req_data[DWIDTH*p +: DWIDTH];
      end
    end
  end

  assign dec[CR_AW] = grant_vld && (gnt_type == TYPE_AW);
  assign dec[CR_W]  = grant_vld && (gnt_type == TYPE_W);
  assign dec[CR_AR] = grant_vld && (gnt_type == TYPE_AR);

  // FSM next state and credit bookkeeping; credit is consumed at grant time.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    err_d    = err_q || (|illegal_req);
    case (state_q)
      ST_INIT: begin
        if (init_load) begin
          state_d         = ST_RUN;
          credit_d[CR_AW] = init_aw_credit;
          credit_d[CR_W]  = init_w_credit;
          credit_d[CR_AR] = init_ar_credit;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < NUM_CR; i++) begin
          if (dec[i] && !cr_ret[i]) begin
            credit_d[i] = credit_q[i] - CR_ONE;
          end else if (cr_ret[i] && !dec[i]) begin
            if (credit_q[i] == CR_MAX) begin
              err_d = 1'b1;
            end else begin
              credit_d[i] = credit_q[i] + CR_ONE;
            end
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : grant_idx + PORT_W'(1);
    end
  end

  // Output stage only loads when empty or draining, so it holds under stall.
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_type_d  = tx_type_q;
    tx_port_d  = tx_port_q;
    if (grant_vld) begin
      tx_valid_d = 1'b1;
      tx_data_d  = gnt_data;
      tx_type_d  = gnt_type;
      tx_port_d  = grant_idx;
    end else if (bus.tx_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      state_q    <= ST_INIT;
      for (int i = 0; i < NUM_CR; i++) credit_q[i] <= '0;
      rr_ptr_q   <= '0;
      err_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_type_q  <= '0;
      tx_port_q  <= '0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      rr_ptr_q   <= rr_ptr_d;
      err_q      <= err_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_type_q  <= tx_type_d;
      tx_port_q  <= tx_port_d;
    end
  end

`ifdef AIB_AXI_ARB_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (tx_valid_q && !bus.tx_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_type  = tx_type_q;
  assign bus.tx_port  = tx_port_q;
  assign credit_aw    = credit_q[CR_AW];
  assign credit_w     = credit_q[CR_W];
  assign credit_ar    = credit_q[CR_AR];
  assign run          = (state_q == ST_RUN);
  assign err          = err_q;

endmodule

// File: tb/tb_aib_axi_credit_arb.sv
// Scoreboard bench for aib_axi_credit_arb: a per-cycle behavioural model predicts
// grants, credits and flags; a separate monitor checks the transmit stream.
module tb_aib_axi_credit_arb;
  import aib_axi_credit_arb_pkg::*;

  localparam int NP   = 4;
  localparam int DW   = 160;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_wr = 1'b0;
  logic          rst_wr;
  logic          init_load;
  logic [CW-1:0] init_aw_credit, init_w_credit, init_ar_credit;
  logic [2:0]    cr_ret;
  logic [CW-1:0] credit_aw, credit_w, credit_ar;
  logic          run, err;
`ifdef AIB_AXI_ARB_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  aib_axi_credit_arb_if #(.NUM_PORTS(NP), .DWIDTH(DW)) bus ();

  aib_axi_credit_arb #(.NUM_PORTS(NP), .DWIDTH(DW), .CREDIT_W(CW)) dut (
    .clk_wr         (clk_wr),
    .rst_wr         (rst_wr),
    .init_load      (init_load),
    .init_aw_credit (init_aw_credit),
    .init_w_credit  (init_w_credit),
    .init_ar_credit (init_ar_credit),
    .cr_ret         (cr_ret),
    .credit_aw      (credit_aw),
    .credit_w       (credit_w),
    .credit_ar      (credit_ar),
    .run            (run),
    .err            (err),
`ifdef AIB_AXI_ARB_STALL_CNT_EN
    .stall_cnt      (stall_cnt),
`endif
    .bus            (bus)
  );

  always #5 clk_wr = ~clk_wr;

  typedef struct {
    int          port;
    int          typ;
    logic [DW-1:0] data;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int m_cr[4];
  int m_rr;
  bit m_txv, m_run, m_err;
  int m_stall;

  // Staged stimulus, applied on the next falling edge
  logic [NP-1:0] s_valid;
  logic [1:0]    s_type[NP];
  logic [DW-1:0] s_data[NP];
  bit            s_ready;
  logic [2:0]    s_cr;
  bit            s_init;
  int            s_iaw, s_iw, s_iar;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic stage_idle();
    s_valid = '0;
    for (int p = 0; p < NP; p++) begin
      s_type[p] = 2'b00;
      s_data[p] = '0;
    end
    s_ready = 1'b1;
    s_cr    = '0;
    s_init  = 1'b0;
  endtask

  task automatic set_req(input int p, input bit v, input int t);
    s_valid[p] = v;
    s_type[p]  = 2'(t);
    s_data[p]  = rand_data();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_cr[i] = 0;
    m_rr = 0; m_txv = 0; m_run = 0; m_err = 0; m_stall = 0;
    exp_q.delete();
  endtask

  task automatic drive();
    bus.req_valid  = s_valid;
    for (int p = 0; p < NP; p++) begin
      bus.req_type[2*p +: 2]  = s_type[p];
      bus.req_data[DW*p +: DW] = s_data[p];
    end
    bus.tx_ready   = s_ready;
    cr_ret         = s_cr;
    init_load      = s_init;
    init_aw_credit = CW'(s_iaw);
    init_w_credit  = CW'(s_iw);
    init_ar_credit = CW'(s_iar);
  endtask

  // One clock: drive, compare DUT against model, then advance the model.
  task automatic step();
    int g;
    int v;
    logic [NP-1:0] exp_rdy;
    @(negedge clk_wr);
    drive();
    #1;
    g = -1;
    for (int i = 0; i < NP; i++) begin
      int p;
      p = (m_rr + i) % NP;
      if (g < 0 && m_run && s_valid[p] && s_type[p] != 2'b11 &&
          m_cr[s_type[p]] > 0 && (!m_txv || s_ready)) g = p;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    chk("tx_valid", 64'(bus.tx_valid), 64'(m_txv));
    chk("run", 64'(run), 64'(m_run));
    chk("err", 64'(err), 64'(m_err));
    chk("credit_aw", 64'(credit_aw), 64'(m_cr[0]));
    chk("credit_w", 64'(credit_w), 64'(m_cr[1]));
    chk("credit_ar", 64'(credit_ar), 64'(m_cr[2]));
`ifdef AIB_AXI_ARB_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    if (!m_run) begin
      if (s_init) begin
        m_run = 1; m_cr[0] = s_iaw; m_cr[1] = s_iw; m_cr[2] = s_iar;
      end
    end else begin
      for (int t = 0; t < 3; t++) begin
        v = m_cr[t] + int'(s_cr[t]);
        if (g >= 0 && int'(s_type[g]) == t) v = v - 1;
        if (v > CMAX) begin
          v = CMAX;
          m_err = 1;
        end
        m_cr[t] = v;
      end
    end
    for (int p = 0; p < NP; p++) if (s_valid[p] && s_type[p] == 2'b11) m_err = 1;
    if (m_txv && !s_ready && m_stall < 65535) m_stall++;
    if (g >= 0) begin
      txn_t e;
      e.port = g; e.typ = int'(s_type[g]); e.data = s_data[g];
      exp_q.push_back(e);
      m_txv = 1;
      m_rr  = (g + 1) % NP;
    end else if (s_ready) begin
      m_txv = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_wr);
    rst_wr = 1'b1;
    stage_idle();
    drive();
    #1;
    chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    chk("rst_run", 64'(run), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_credits", 64'({credit_aw, credit_w, credit_ar}), 64'd0);
    chk("rst_tx_word", 64'({bus.tx_data[31:0], bus.tx_type, bus.tx_port}), 64'd0);
    model_reset();
    @(negedge clk_wr);
    rst_wr = 1'b0;
  endtask

  task automatic do_init(input int aw, input int w, input int ar);
    s_iaw = aw; s_iw = w; s_iar = ar;
    s_init = 1'b1;
    step();
    s_init = 1'b0;
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: the word on the stream must match the oldest outstanding grant.
  initial begin
    forever begin
      @(negedge clk_wr);
      #2;
      if (bus.tx_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected actual port %0d expected no word", bus.tx_port);
        end else begin
          chk("tx_port", 64'(bus.tx_port), 64'(exp_q[0].port));
          chk("tx_type", 64'(bus.tx_type), 64'(exp_q[0].typ));
          checks++;
          if (bus.tx_data !== exp_q[0].data) begin
            errors++;
            $display("FAIL tx_data actual %h expected %h", bus.tx_data, exp_q[0].data);
          end
          if (bus.tx_ready === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_wr = 1'b1;
    s_iaw = 0; s_iw = 0; s_iar = 0;
    stage_idle();
    drive();
    model_reset();
    do_reset();

    // INIT ignores requests and credit returns, then loads 2/3/1
    for (int p = 0; p < NP; p++) set_req(p, 1, 0);
    s_cr = 3'b111;
    run_steps(3);
    stage_idle();
    do_init(2, 3, 1);
    step();

    // Four ports contending for eight W credits
    do_reset();
    do_init(0, 8, 0);
    for (int i = 0; i < 12; i++) begin
      for (int p = 0; p < NP; p++) set_req(p, 1, 1);
      step();
    end

    // Starved AW port must not block AR; AW resumes after a credit return
    stage_idle();
    do_reset();
    do_init(0, 0, 2);
    set_req(0, 1, 0);
    set_req(1, 1, 2);
    run_steps(3);
    s_cr = 3'b001;
    step();
    s_cr = 3'b000;
    run_steps(3);

    // Five-cycle transmit stall
    stage_idle();
    do_reset();
    do_init(10, 10, 10);
    for (int p = 0; p < NP; p++) set_req(p, 1, p % 3);
    run_steps(2);
    s_ready = 1'b0;
    run_steps(5);
    s_ready = 1'b1;
    run_steps(4);

    // AR credit saturation
    stage_idle();
    do_reset();
    do_init(0, 0, 255);
    s_cr = 3'b100;
    step();
    s_cr = 3'b000;
    run_steps(2);

    // Illegal type on port 2 with other ports active
    do_reset();
    do_init(5, 5, 5);
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1, 0); set_req(1, 1, 1); set_req(2, 1, 3); set_req(3, 1, 2);
      step();
    end

    // Grant and return of AW in the same cycle
    stage_idle();
    do_reset();
    do_init(3, 0, 0);
    set_req(0, 1, 0);
    s_cr = 3'b001;
    step();
    stage_idle();
    run_steps(2);

    // Randomised traffic with a reset in the middle
    do_reset();
    do_init($urandom_range(6, 1), $urandom_range(6, 1), $urandom_range(6, 1));
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        do_reset();
        do_init($urandom_range(4, 0), $urandom_range(4, 0), $urandom_range(4, 0));
      end
      for (int p = 0; p < NP; p++)
        set_req(p, $urandom_range(3, 0) != 0, ($urandom_range(19, 0) == 0) ? 3 : $urandom_range(2, 0));
      s_ready = $urandom_range(9, 0) < 7;
      s_cr    = {$urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0};
      step();
    end

    // Reset while a stalled word is pending drops it immediately
    stage_idle();
    do_reset();
    do_init(2, 2, 2);
    set_req(1, 1, 1);
    s_ready = 1'b0;
    run_steps(2);
    do_reset();
    run_steps(2);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
